// File: rtl/bip_data_ram.sv
// BIP data memory: falling-edge single-port RAM with write-through, illegal-access
// flagging and a clear sequencer that zeroes every word after reset or on request.
module bip_data_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              addr_err_o,
    output logic              busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AXT_W = ADDR_W + 1;

    typedef enum logic {ST_CLEARING, ST_IDLE} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                addr_err_q, addr_err_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range_c;
    logic [PTR_W-1:0]    addr_idx_c;
    logic                we_c;
    logic [PTR_W-1:0]    waddr_c;
    logic [DATA_W-1:0]   wdata_c;

    // Extra top bit so DEPTH == 2**ADDR_W still compares correctly.
    assign in_range_c = ({1'b0, addr_i} < AXT_W'(DEPTH));
    assign addr_idx_c = PTR_W'(addr_i);

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        addr_err_d  = 1'b0;
        busy_d      = busy_q;
        we_c        = 1'b0;
        waddr_c     = clr_ptr_q;
        wdata_c     = '0;

        unique case (state_q)
            ST_CLEARING: begin
                we_c = ~reset_i;
                if (clr_ptr_q == PTR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    clr_ptr_d = clr_ptr_q + PTR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clear_i) begin
                    state_d   = ST_CLEARING;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end else if (rd_i || wr_i) begin
                    if ((rd_i && wr_i) || !in_range_c) begin
                        addr_err_d = 1'b1;
                    end else if (wr_i) begin
                        we_c        = ~reset_i;
                        waddr_c     = addr_idx_c;
                        wdata_c     = in_data_i;
                        out_data_d  = in_data_i;
                        out_valid_d = 1'b1;
                    end else begin
                        out_data_d  = mem_q[addr_idx_c];
                        out_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEARING;
            end
        endcase
    end

    // Control and output registers; reset restarts the clear from word 0.
    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_CLEARING;
            clr_ptr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            addr_err_q  <= addr_err_d;
            busy_q      <= busy_d;
        end
    end

    // Storage array is deliberately not reset; the clear sequencer zeroes it.
    always_ff @(negedge clk_i) begin
        if (we_c) begin
            mem_q[waddr_c] <= wdata_c;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign addr_err_o  = addr_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bip_data_ram.sv
// Directed testbench for bip_data_ram with DEPTH=16: clear sequencing, access
// decode, illegal requests and clear/reset collisions.
module tb_bip_data_ram;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 16;

    logic              clk;
    logic              reset;
    logic              rd;
    logic              wr;
    logic              clear;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              addr_err;
    logic              busy;

    int checks;
    int passed;

    bip_data_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rd_i        (rd),
        .wr_i        (wr),
        .clear_i     (clear),
        .addr_i      (addr),
        .in_data_i   (in_data),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .addr_err_o  (addr_err),
        .busy_o      (busy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // One falling edge, then settle before sampling.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic access(input logic r, input logic w, input logic c,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rd = r; wr = w; clear = c; addr = a; in_data = d;
        tick();
        rd = 1'b0; wr = 1'b0; clear = 1'b0;
    endtask

    // Counts edges until BUSY drops (bounded at 100).
    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b1, 1'b0, 1'b0, ADDR_W'(i), '0);
            checks++;
            if (out_data !== 16'h0000 || out_valid !== 1'b1)
                $display("FAIL %s_rd%0d got data=%h valid=%b exp data=0000 valid=1", tag, i, out_data, out_valid);
            else passed++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || addr_err !== 1'b0 || out_data !== 16'h0000)
            $display("FAIL reset_state got busy=%b valid=%b err=%b data=%h exp 1 0 0 0000", busy, out_valid, addr_err, out_data);
        else passed++;
        wait_busy_low(n);
        checks++;
        if (n != int'(DEPTH)) $display("FAIL reset_busy_edges got %0d exp %0d", n, DEPTH);
        else passed++;
        read_all_zero("reset");
    endtask

    task automatic test_write_read();
        access(1'b0, 1'b1, 1'b0, 11'd5, 16'hBEEF);
        checks++;
        if (out_data !== 16'hBEEF || out_valid !== 1'b1)
            $display("FAIL wr5 got data=%h valid=%b exp BEEF 1", out_data, out_valid);
        else passed++;
        access(1'b1, 1'b0, 1'b0, 11'd5, 16'h0000);
        checks++;
        if (out_data !== 16'hBEEF || out_valid !== 1'b1)
            $display("FAIL rd5 got data=%h valid=%b exp BEEF 1", out_data, out_valid);
        else passed++;
        access(1'b1, 1'b0, 1'b0, 11'd6, 16'h0000);
        checks++;
        if (out_data !== 16'h0000 || out_valid !== 1'b1)
            $display("FAIL rd6 got data=%h valid=%b exp 0000 1", out_data, out_valid);
        else passed++;
    endtask

    task automatic test_idle();
        access(1'b1, 1'b0, 1'b0, 11'd5, 16'h0000);
        access(1'b0, 1'b0, 1'b0, 11'd5, 16'h1111);
        checks++;
        if (out_data !== 16'h0000 || out_valid !== 1'b0 || addr_err !== 1'b0)
            $display("FAIL idle got data=%h valid=%b err=%b exp 0000 0 0", out_data, out_valid, addr_err);
        else passed++;
    endtask

    task automatic test_illegal();
        access(1'b1, 1'b0, 1'b0, 11'(DEPTH), 16'h0000);
        checks++;
        if (addr_err !== 1'b1 || out_data !== 16'h0000 || out_valid !== 1'b0)
            $display("FAIL rd_oob got err=%b data=%h valid=%b exp 1 0000 0", addr_err, out_data, out_valid);
        else passed++;
        access(1'b0, 1'b1, 1'b0, 11'd3, 16'h1234);
        access(1'b1, 1'b1, 1'b0, 11'd3, 16'hFFFF);
        checks++;
        if (addr_err !== 1'b1 || out_data !== 16'h0000 || out_valid !== 1'b0)
            $display("FAIL rdwr got err=%b data=%h valid=%b exp 1 0000 0", addr_err, out_data, out_valid);
        else passed++;
        access(1'b1, 1'b0, 1'b0, 11'd3, 16'h0000);
        checks++;
        if (out_data !== 16'h1234 || addr_err !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL rd3_after_rdwr got data=%h err=%b valid=%b exp 1234 0 1", out_data, addr_err, out_valid);
        else passed++;
        // Out-of-range write must not alias onto a low word.
        access(1'b0, 1'b1, 1'b0, 11'd2047, 16'hDEAD);
        checks++;
        if (addr_err !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL wr_oob got err=%b valid=%b exp 1 0", addr_err, out_valid);
        else passed++;
        access(1'b1, 1'b0, 1'b0, 11'd15, 16'h0000);
        checks++;
        if (out_data !== 16'h0000 || addr_err !== 1'b0)
            $display("FAIL rd15_after_wr_oob got data=%h err=%b exp 0000 0", out_data, addr_err);
        else passed++;
        access(1'b0, 1'b1, 1'b0, 11'(DEPTH), 16'hDEAD);
        access(1'b1, 1'b0, 1'b0, 11'd0, 16'h0000);
        checks++;
        if (out_data !== 16'h0000) $display("FAIL rd0_after_wr16 got %h exp 0000", out_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 8; i < 12; i++)
            access(1'b0, 1'b1, 1'b0, ADDR_W'(i), DATA_W'(16'hA000 + i));
        for (int i = 8; i < 12; i++) begin
            access(1'b1, 1'b0, 1'b0, ADDR_W'(i), '0);
            checks++;
            if (out_data !== DATA_W'(16'hA000 + i) || out_valid !== 1'b1)
                $display("FAIL b2b_rd%0d got data=%h valid=%b exp %h 1", i, out_data, out_valid, 16'hA000 + i);
            else passed++;
        end
    endtask

    task automatic test_clear_collision();
        int n;
        access(1'b0, 1'b1, 1'b1, 11'd2, 16'h0007);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000)
            $display("FAIL clr_coll got busy=%b valid=%b data=%h exp 1 0 0000", busy, out_valid, out_data);
        else passed++;
        // Requests during the clear are ignored.
        access(1'b0, 1'b1, 1'b0, 11'd9, 16'hAAAA);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL wr_while_busy got valid=%b busy=%b exp 0 1", out_valid, busy);
        else passed++;
        wait_busy_low(n);
        checks++;
        if (n != int'(DEPTH) - 1) $display("FAIL clr_busy_edges got %0d exp %0d", n + 1, DEPTH);
        else passed++;
        access(1'b1, 1'b0, 1'b0, 11'd2, 16'h0000);
        checks++;
        if (out_data !== 16'h0000 || out_valid !== 1'b1)
            $display("FAIL rd2_after_clr got data=%h valid=%b exp 0000 1", out_data, out_valid);
        else passed++;
        access(1'b1, 1'b0, 1'b0, 11'd9, 16'h0000);
        checks++;
        if (out_data !== 16'h0000) $display("FAIL rd9_after_clr got %h exp 0000", out_data);
        else passed++;
        access(1'b1, 1'b0, 1'b0, 11'd5, 16'h0000);
        checks++;
        if (out_data !== 16'h0000) $display("FAIL rd5_after_clr got %h exp 0000", out_data);
        else passed++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        access(1'b0, 1'b1, 1'b0, 11'd12, 16'h5555);
        access(1'b0, 1'b1, 1'b0, 11'd15, 16'h6666);
        access(1'b0, 1'b0, 1'b1, 11'd0, 16'h0000);
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL midclr_reset_busy got %b exp 1", busy);
        else passed++;
        wait_busy_low(n);
        checks++;
        if (n != int'(DEPTH)) $display("FAIL midclr_busy_edges got %0d exp %0d", n, DEPTH);
        else passed++;
        read_all_zero("midclr");
    endtask

    initial begin
        checks = 0; passed = 0;
        reset = 1'b0; rd = 1'b0; wr = 1'b0; clear = 1'b0; addr = '0; in_data = '0;
        test_reset();
        test_write_read();
        test_idle();
        test_illegal();
        test_back_to_back();
        test_clear_collision();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
